// File: rtl/key_cmd_pkg.sv
// Shared constants for the key_cmd command decoder: scan codes, key_event
// field positions and the per-player direction key indices.
package key_cmd_pkg;

    // Player-1 movement (no E0 prefix)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_D     = 8'h23;
    // Player-2 movement (E0-prefixed arrows)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    // System keys (no E0 prefix)
    localparam logic [7:0] SC_M     = 8'h3A;
    localparam logic [7:0] SC_P     = 8'h4D;
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_R     = 8'h2D;

    // key_event field positions
    localparam int unsigned KE_VALID    = 10;
    localparam int unsigned KE_E0       = 9;
    localparam int unsigned KE_BRK      = 8;
    localparam int unsigned KE_CODE_MSB = 7;

    // Direction key slots inside one player's key_repeat
    localparam int unsigned KEY_W = 0;
    localparam int unsigned KEY_A = 1;
    localparam int unsigned KEY_S = 2;
    localparam int unsigned KEY_D = 3;

    // One-hot direction slot for a scan code; arrows selects the player-2 set
    function automatic logic [3:0] dir_onehot(input logic [7:0] code, input logic arrows);
        logic [3:0] hit;
        hit = '0;
        if (!arrows) begin
            hit[KEY_W] = (code == SC_W);
            hit[KEY_A] = (code == SC_A);
            hit[KEY_S] = (code == SC_S);
            hit[KEY_D] = (code == SC_D);
        end else begin
            hit[KEY_W] = (code == SC_UP);
            hit[KEY_A] = (code == SC_LEFT);
            hit[KEY_S] = (code == SC_DOWN);
            hit[KEY_D] = (code == SC_RIGHT);
        end
        return hit;
    endfunction

endpackage

// File: rtl/key_cmd_if.sv
// Bundle between the keyboard record source and the key_cmd outputs.
interface key_cmd_if;
    logic [10:0] key_event;
    logic        w1, a1, s1, d1;
    logic        w2, a2, s2, d2;
    logic        music_en;
    logic        run;
    logic        started;
    logic        game_rstn;

    modport master (
        output key_event,
        input  w1, a1, s1, d1, w2, a2, s2, d2, music_en, run, started, game_rstn
    );

    modport slave (
        input  key_event,
        output w1, a1, s1, d1, w2, a2, s2, d2, music_en, run, started, game_rstn
    );
endinterface

// File: rtl/key_repeat.sv
// Per-player held flags plus delayed auto-shift on the a/s/d keys.
// The most recent repeatable make owns the single repeat counter.
module key_repeat
    import key_cmd_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 16_000_000,
    parameter int unsigned ARR_CYCLES = 5_000_000,
    parameter int unsigned CNT_W      = 24
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic [3:0] make_i,
    input  logic [3:0] brk_i,
    input  logic       clr_i,
    output logic [3:0] pulse_o
);

    localparam logic [CNT_W-1:0] DasLoad = CNT_W'(DAS_CYCLES - 1);
    localparam logic [CNT_W-1:0] ArrLoad = CNT_W'(ARR_CYCLES - 1);

    logic [3:0]       held_q, held_d;
    logic [3:0]       pulse_q, pulse_d;
    logic [1:0]       act_q, act_d;
    logic             act_vld_q, act_vld_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             expire;

    // Next-state: breaks, then makes (a fresh make overrides a same-cycle expiry)
    always_comb begin
        held_d    = held_q & ~brk_i;
        act_d     = act_q;
        act_vld_d = act_vld_q;
        cnt_d     = cnt_q;
        pulse_d   = '0;
        // Breaking the active key in its expiry cycle stops the repeat outright
        expire    = act_vld_q && (cnt_q == '0) && !brk_i[act_q];

        if (act_vld_q) begin
            cnt_d = (cnt_q == '0) ? ArrLoad : cnt_q - 1'b1;
            if (brk_i[act_q]) begin
                act_vld_d = 1'b0;
            end
        end

        for (int unsigned k = 0; k < 4; k++) begin
            if (make_i[k] && !held_q[k]) begin
                held_d[k]  = 1'b1;
                pulse_d[k] = 1'b1;
                if (k != KEY_W) begin
                    act_d     = k[1:0];
                    act_vld_d = 1'b1;
                    cnt_d     = DasLoad;
                    expire    = 1'b0;
                end
            end
        end

        if (expire) begin
            pulse_d[act_q] = 1'b1;
        end

        if (clr_i) begin
            held_d    = '0;
            act_d     = '0;
            act_vld_d = 1'b0;
            cnt_d     = '0;
            pulse_d   = '0;
        end
    end

    // State registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            held_q    <= '0;
            pulse_q   <= '0;
            act_q     <= '0;
            act_vld_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            held_q    <= held_d;
            pulse_q   <= pulse_d;
            act_q     <= act_d;
            act_vld_q <= act_vld_d;
            cnt_q     <= cnt_d;
        end
    end

    assign pulse_o = pulse_q;

endmodule

// File: rtl/key_cmd.sv
// Key event decoder: record acceptance, key map, system state and game soft reset.
module key_cmd
    import key_cmd_pkg::*;
#(
    parameter int unsigned DAS_CYCLES = 16_000_000,
    parameter int unsigned ARR_CYCLES = 5_000_000,
    parameter int unsigned CNT_W      = 24
) (
    input logic      clk,
    input logic      rstn,
    key_cmd_if.slave kif
);

    logic [10:0] ev;
    logic        valid_prev_q;
    logic [9:0]  last_q;
    logic        accept, e0, brk, sys;
    logic [7:0]  code;
    logic [3:0]  hit1, hit2, make1, make2, brk1, brk2, pulse1, pulse2;
    logic        cmd_m, cmd_p, cmd_space, cmd_r;
    logic        music_q, music_d, run_q, run_d, started_q, started_d, grst_q, grst_d;

    assign ev = kif.key_event;

    // Decode the accepted record into per-player strobes and system commands
    always_comb begin
        accept    = ev[KE_VALID] && (!valid_prev_q || (ev[KE_E0:0] != last_q));
        e0        = ev[KE_E0];
        brk       = ev[KE_BRK];
        code      = ev[KE_CODE_MSB:0];
        hit1      = (accept && !e0) ? dir_onehot(code, 1'b0) : 4'b0000;
        hit2      = (accept && e0) ? dir_onehot(code, 1'b1) : 4'b0000;
        make1     = brk ? 4'b0000 : hit1;
        brk1      = brk ? hit1 : 4'b0000;
        make2     = brk ? 4'b0000 : hit2;
        brk2      = brk ? hit2 : 4'b0000;
        sys       = accept && !e0 && !brk;
        cmd_m     = sys && (code == SC_M);
        cmd_p     = sys && (code == SC_P);
        cmd_space = sys && (code == SC_SPACE);
        cmd_r     = sys && (code == SC_R);
    end

    // System next-state; R and P both win over Space since only one code arrives per cycle
    always_comb begin
        music_d   = music_q ^ cmd_m;
        run_d     = run_q;
        started_d = started_q;
        grst_d    = !cmd_r;
        if (cmd_space) begin
            run_d     = 1'b1;
            started_d = 1'b1;
        end
        if (cmd_p || cmd_r) begin
            run_d = 1'b0;
        end
        if (cmd_r) begin
            started_d = 1'b0;
        end
    end

    // Acceptance history and system registers
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            valid_prev_q <= 1'b0;
            last_q       <= '0;
            music_q      <= 1'b0;
            run_q        <= 1'b0;
            started_q    <= 1'b0;
            grst_q       <= 1'b1;
        end else begin
            valid_prev_q <= ev[KE_VALID];
            if (accept) begin
                last_q <= ev[KE_E0:0];
            end
            music_q   <= music_d;
            run_q     <= run_d;
            started_q <= started_d;
            grst_q    <= grst_d;
        end
    end

    key_repeat #(
        .DAS_CYCLES (DAS_CYCLES),
        .ARR_CYCLES (ARR_CYCLES),
        .CNT_W      (CNT_W)
    ) u_rep_p1 (
        .clk     (clk),
        .rstn    (rstn),
        .make_i  (make1),
        .brk_i   (brk1),
        .clr_i   (cmd_r),
        .pulse_o (pulse1)
    );

    key_repeat #(
        .DAS_CYCLES (DAS_CYCLES),
        .ARR_CYCLES (ARR_CYCLES),
        .CNT_W      (CNT_W)
    ) u_rep_p2 (
        .clk     (clk),
        .rstn    (rstn),
        .make_i  (make2),
        .brk_i   (brk2),
        .clr_i   (cmd_r),
        .pulse_o (pulse2)
    );

    assign kif.w1        = pulse1[KEY_W];
    assign kif.a1        = pulse1[KEY_A];
    assign kif.s1        = pulse1[KEY_S];
    assign kif.d1        = pulse1[KEY_D];
    assign kif.w2        = pulse2[KEY_W];
    assign kif.a2        = pulse2[KEY_A];
    assign kif.s2        = pulse2[KEY_S];
    assign kif.d2        = pulse2[KEY_D];
    assign kif.music_en  = music_q;
    assign kif.run       = run_q;
    assign kif.started   = started_q;
    assign kif.game_rstn = grst_q;

endmodule

// File: tb/tb_key_cmd.sv
// Testbench for key_cmd: directed scenarios plus random records, each cycle
// compared against a timestamp-based reference model.
module tb_key_cmd;

    localparam int DAS = 20;
    localparam int ARR = 5;

    logic clk  = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    key_cmd_if kif ();

    key_cmd #(
        .DAS_CYCLES (DAS),
        .ARR_CYCLES (ARR),
        .CNT_W      (8)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .kif  (kif)
    );

    wire [11:0] obs = {kif.w1, kif.a1, kif.s1, kif.d1, kif.w2, kif.a2, kif.s2, kif.d2,
                       kif.music_en, kif.run, kif.started, kif.game_rstn};

    int vectors = 0;
    int errors  = 0;

    // Reference model: sets of held keys, active key, absolute edge of next repeat
    bit         m_held  [2][4];
    bit         m_pulse [2][4];
    bit         m_act_v [2];
    int         m_act   [2];
    int         m_rep   [2];
    bit         m_music, m_run, m_started, m_grst, m_pv;
    logic [9:0] m_last;
    int         m_n = 0;

    function automatic logic [7:0] dir_code(input int idx);
        case (idx)
            0: return 8'h1D;
            1: return 8'h1C;
            2: return 8'h1B;
            3: return 8'h23;
            4: return 8'h75;
            5: return 8'h6B;
            6: return 8'h72;
            default: return 8'h74;
        endcase
    endfunction

    function logic [11:0] exp_vec();
        return {m_pulse[0][0], m_pulse[0][1], m_pulse[0][2], m_pulse[0][3],
                m_pulse[1][0], m_pulse[1][1], m_pulse[1][2], m_pulse[1][3],
                m_music, m_run, m_started, m_grst};
    endfunction

    task automatic model_reset();
        for (int p = 0; p < 2; p++) begin
            for (int k = 0; k < 4; k++) begin
                m_held[p][k]  = 1'b0;
                m_pulse[p][k] = 1'b0;
            end
            m_act_v[p] = 1'b0;
            m_act[p]   = 0;
            m_rep[p]   = 0;
        end
        m_music = 0; m_run = 0; m_started = 0; m_grst = 1; m_pv = 0; m_last = '0;
    endtask

    task automatic model_edge(input logic [10:0] ev);
        bit acc, e0, br;
        bit expire [2];
        int p, k;
        logic [7:0] c;
        acc = ev[10] && (!m_pv || ev[9:0] != m_last);
        m_pv = ev[10];
        if (acc) m_last = ev[9:0];
        e0 = ev[9]; br = ev[8]; c = ev[7:0];
        m_grst = 1;
        p = -1; k = -1;
        for (int pp = 0; pp < 2; pp++) begin
            for (int kk = 0; kk < 4; kk++) begin
                m_pulse[pp][kk] = 0;
                if (acc && c == dir_code(pp * 4 + kk) && e0 == (pp == 1)) begin
                    p = pp; k = kk;
                end
            end
            expire[pp] = m_act_v[pp] && (m_rep[pp] == m_n);
        end
        if (p >= 0) begin
            if (br) begin
                m_held[p][k] = 0;
                if (m_act_v[p] && m_act[p] == k) begin
                    m_act_v[p] = 0;
                    expire[p]  = 0;
                end
            end else if (!m_held[p][k]) begin
                m_held[p][k]  = 1;
                m_pulse[p][k] = 1;
                if (k != 0) begin
                    m_act[p]   = k;
                    m_act_v[p] = 1;
                    m_rep[p]   = m_n + DAS;
                    expire[p]  = 0;
                end
            end
        end
        for (int pp = 0; pp < 2; pp++) begin
            if (expire[pp]) begin
                m_pulse[pp][m_act[pp]] = 1;
                m_rep[pp] = m_n + ARR;
            end
        end
        if (acc && !e0 && !br) begin
            case (c)
                8'h3A: m_music = !m_music;
                8'h4D: m_run = 0;
                8'h29: begin m_run = 1; m_started = 1; end
                8'h2D: begin
                    m_grst = 0; m_run = 0; m_started = 0;
                    for (int pp = 0; pp < 2; pp++) begin
                        m_act_v[pp] = 0;
                        for (int kk = 0; kk < 4; kk++) begin
                            m_held[pp][kk]  = 0;
                            m_pulse[pp][kk] = 0;
                        end
                    end
                end
                default: ;
            endcase
        end
        m_n++;
    endtask

    // Drive one record for one cycle; returns at the following negedge
    task automatic step(input logic [10:0] ev);
        kif.key_event = ev;
        @(posedge clk);
        model_edge(ev);
        @(negedge clk);
    endtask

    task automatic test_reset();
        kif.key_event = '0;
        rstn = 1'b0;
        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (obs !== 12'h001) begin
            errors++;
            $display("FAIL reset_state obs=%b exp=%b", obs, 12'h001);
        end
        model_reset();
        rstn = 1'b1;
    endtask

    task automatic test_single_make();
        int w1_cnt = 0;
        for (int i = 0; i < 40; i++) begin
            step(i < 3 ? 11'h41D : (i == 3 ? 11'h51D : 11'h000));
            vectors++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL single_make i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
            if (kif.w1 === 1'b1) w1_cnt++;
            if (i == 0) begin
                vectors++;
                if (kif.w1 !== 1'b1) begin
                    errors++;
                    $display("FAIL single_make_latency w1=%b exp=1", kif.w1);
                end
            end
        end
        vectors++;
        if (w1_cnt != 1) begin
            errors++;
            $display("FAIL single_make_count w1_pulses=%0d exp=1", w1_cnt);
        end
    endtask

    task automatic test_auto_repeat();
        bit want;
        for (int i = 0; i < 50; i++) begin
            step(i < 40 ? 11'h66B : (i == 40 ? 11'h76B : 11'h000));
            want = (i + 1) inside {1, 21, 26, 31, 36};
            vectors++;
            if (obs !== exp_vec() || kif.a2 !== want) begin
                errors++;
                $display("FAIL auto_repeat t=%0d obs=%b exp=%b a2_exp=%b", i + 1, obs, exp_vec(),
                         want);
            end
        end
    endtask

    task automatic test_typematic();
        logic [10:0] seq [12] = '{11'h41C, 11'h41C, 11'h41D, 11'h41C, 11'h41C, 11'h61D,
                                  11'h61D, 11'h51C, 11'h51D, 11'h000, 11'h000, 11'h000};
        int a1_cnt = 0;
        int w1_cnt = 0;
        for (int i = 0; i < 12; i++) begin
            step(seq[i]);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL typematic i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
            if (kif.a1 === 1'b1) a1_cnt++;
            if (kif.w1 === 1'b1) w1_cnt++;
        end
        vectors++;
        if (a1_cnt != 1 || w1_cnt != 1) begin
            errors++;
            $display("FAIL typematic_count a1=%0d w1=%0d exp=1,1", a1_cnt, w1_cnt);
        end
    endtask

    task automatic test_last_pressed();
        bit want;
        int a1_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            step(11'h41C);
            if (kif.a1 === 1'b1) a1_cnt++;
        end
        for (int i = 0; i < 60; i++) begin
            step(i < 50 ? 11'h423 : (i == 50 ? 11'h523 : (i == 51 ? 11'h51C : 11'h000)));
            want = (i + 1) inside {1, 21, 26, 31, 36, 41, 46};
            if (kif.a1 === 1'b1) a1_cnt++;
            vectors++;
            if (obs !== exp_vec() || kif.d1 !== want) begin
                errors++;
                $display("FAIL last_pressed t=%0d obs=%b exp=%b d1_exp=%b", i + 1, obs, exp_vec(),
                         want);
            end
        end
        vectors++;
        if (a1_cnt != 1) begin
            errors++;
            $display("FAIL last_pressed_a1 a1_pulses=%0d exp=1", a1_cnt);
        end
    endtask

    task automatic test_system();
        logic [10:0] seq [10] = '{11'h429, 11'h44D, 11'h43A, 11'h000, 11'h53A,
                                  11'h43A, 11'h429, 11'h42D, 11'h000, 11'h45A};
        logic [3:0] want [10] = '{4'b0111, 4'b0011, 4'b1011, 4'b1011, 4'b1011,
                                  4'b0011, 4'b0111, 4'b0000, 4'b0001, 4'b0001};
        for (int i = 0; i < 10; i++) begin
            step(seq[i]);
            vectors++;
            if (obs !== exp_vec() || obs[3:0] !== want[i]) begin
                errors++;
                $display("FAIL system i=%0d obs=%b exp=%b sys_exp=%b", i, obs, exp_vec(), want[i]);
            end
        end
    endtask

    task automatic test_reset_mid_repeat();
        step(11'h43A);
        step(11'h000);
        for (int i = 0; i < 28; i++) begin
            step(11'h41B);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL reset_mid_hold i=%0d obs=%b exp=%b", i, obs, exp_vec());
            end
        end
        rstn = 1'b0;
        #1;
        vectors++;
        if (obs !== 12'h001) begin
            errors++;
            $display("FAIL reset_mid_async obs=%b exp=%b", obs, 12'h001);
        end
        kif.key_event = '0;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 40; i++) begin
            step(11'h000);
            vectors++;
            if (obs !== exp_vec() || obs !== 12'h001) begin
                errors++;
                $display("FAIL reset_mid_after i=%0d obs=%b exp=%b", i, obs, 12'h001);
            end
        end
    endtask

    task automatic test_random();
        logic [10:0] ev = '0;
        logic [7:0]  c;
        logic        e0;
        int          sel;
        for (int i = 0; i < 800; i++) begin
            if ($urandom_range(0, 9) >= 3) begin
                sel = $urandom_range(0, 13);
                if (sel < 8) c = dir_code(sel);
                else if (sel == 8) c = 8'h3A;
                else if (sel == 9) c = 8'h4D;
                else if (sel == 10) c = 8'h29;
                else if (sel == 11) c = 8'h11;
                else c = ($urandom_range(0, 39) == 0) ? 8'h2D : 8'h5A;
                e0 = (sel >= 4 && sel < 8) ? ($urandom_range(0, 4) != 0)
                                           : ($urandom_range(0, 4) == 0);
                ev = {($urandom_range(0, 7) != 0), e0, ($urandom_range(0, 99) < 35), c};
            end
            step(ev);
            vectors++;
            if (obs !== exp_vec()) begin
                errors++;
                $display("FAIL random i=%0d ev=%h obs=%b exp=%b", i, ev, obs, exp_vec());
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_make();
        test_auto_repeat();
        test_typematic();
        test_last_pressed();
        test_system();
        test_reset_mid_repeat();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
